// File: rtl/tea_stream_adapter.sv
`timescale 1ns/1ps
// Byte-stream wrapper around the TEA encrypt core: packs bytes MSB-first into two
// half-words, launches the core, waits (with timeout) and serialises the result.
module tea_stream_adapter #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_WIDTH  = 8,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic [7:0]             out_data,
  output logic                   out_valid,
  output logic                   out_last,
  input  logic                   out_ready,
  output logic                   core_start,
  output logic [DATA_WIDTH-1:0]  core_v0,
  output logic [DATA_WIDTH-1:0]  core_v1,
  input  logic                   core_ready,
  input  logic [DATA_WIDTH-1:0]  core_o0,
  input  logic [DATA_WIDTH-1:0]  core_o1,
  output logic                   timeout_err,
  output logic [COUNT_WIDTH-1:0] block_count
);

  localparam int NB = 2 * DATA_WIDTH / 8;
  localparam int BW = 2 * DATA_WIDTH;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NB - 1);
  localparam logic [TIMEOUT_WIDTH-1:0] TIMER_MAX = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] S_FILL   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_DRAIN  = 2'd3;

  logic [1:0]               state;
  logic [BW-1:0]            in_buf;
  logic [BW-1:0]            out_buf;
  logic [CW-1:0]            byte_cnt;
  logic [CW-1:0]            out_cnt;
  logic [TIMEOUT_WIDTH-1:0] timer;
  logic                     last_flag;

  // Handshake: a byte moves on in_valid && in_ready (FILL only); an output byte
  // moves on out_valid && out_ready (DRAIN only); outputs hold while stalled.
  assign in_ready   = (state == S_FILL);
  assign out_valid  = (state == S_DRAIN);
  assign out_data   = out_valid ? out_buf[BW-1 -: 8] : 8'd0;
  assign out_last   = out_valid && last_flag && (out_cnt == LAST_IDX);
  assign core_start = (state == S_LAUNCH);
  assign core_v0    = in_buf[BW-1 -: DATA_WIDTH];
  assign core_v1    = in_buf[DATA_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_FILL;
      in_buf      <= '0;
      out_buf     <= '0;
      byte_cnt    <= '0;
      out_cnt     <= '0;
      timer       <= '0;
      last_flag   <= 1'b0;
      timeout_err <= 1'b0;
      block_count <= '0;
    end else begin
      case (state)
        S_FILL: begin
          if (in_valid) begin
            for (int i = 0; i < NB; i++) begin
              if (byte_cnt == CW'(i)) in_buf[(NB-1-i)*8 +: 8] <= in_data;
            end
            if (in_last || byte_cnt == LAST_IDX) begin
              state     <= S_LAUNCH;
              last_flag <= in_last;
              byte_cnt  <= '0;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
        end
        S_LAUNCH: begin
          timer <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // A done pulse on the last allowed cycle still counts as success.
          if (core_ready) begin
            out_buf <= {core_o0, core_o1};
            out_cnt <= '0;
            state   <= S_DRAIN;
          end else if (timer == TIMER_MAX) begin
            timeout_err <= 1'b1;
            in_buf      <= '0;
            last_flag   <= 1'b0;
            state       <= S_FILL;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_DRAIN: begin
          if (out_ready) begin
            out_buf <= out_buf << 8;
            if (out_cnt == LAST_IDX) begin
              block_count <= block_count + 1'b1;
              out_cnt     <= '0;
              last_flag   <= 1'b0;
              in_buf      <= '0;
              state       <= S_FILL;
            end else begin
              out_cnt <= out_cnt + 1'b1;
            end
          end
        end
        default: state <= S_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_tea_stream_adapter.sv
`timescale 1ns/1ps
// Bench for tea_stream_adapter: stub core returns the bitwise inverse after a set
// latency; expected output bytes come from a padded-block reference model.
module tb_tea_stream_adapter;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_last;
  logic        out_ready;
  logic        core_start;
  logic [31:0] core_v0;
  logic [31:0] core_v1;
  logic        core_ready;
  logic [31:0] core_o0;
  logic [31:0] core_o1;
  logic        timeout_err;
  logic [15:0] block_count;

  tea_stream_adapter dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .core_start(core_start), .core_v0(core_v0), .core_v1(core_v1),
    .core_ready(core_ready), .core_o0(core_o0), .core_o1(core_o1),
    .timeout_err(timeout_err), .block_count(block_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_blocks = 0;
  int n_acc = 0;
  int stub_n = 0;
  int stub_cnt = 0;
  int ready_mode = 0;
  logic [8:0] exp_q[$];

  // Stub core: done pulse stub_n cycles after start (0 = never answers).
  always @(posedge clk) begin
    if (rst) stub_cnt <= 0;
    else if (core_start) stub_cnt <= stub_n;
    else if (stub_cnt > 0) stub_cnt <= stub_cnt - 1;
  end
  assign core_ready = (stub_cnt == 1);
  assign core_o0 = ~core_v0;
  assign core_o1 = ~core_v1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Downstream ready pattern: 0 = always, 1 = alternating, 2 = random.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (ready_mode)
        1:       out_ready = ~out_ready;
        2:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Output monitor / scoreboard.
  initial begin
    logic       stalled_prev;
    logic [9:0] prev;
    logic [8:0] e;
    stalled_prev = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        stalled_prev = 1'b0;
      end else begin
        if (stalled_prev) check("stall_hold", {out_valid, out_last, out_data}, prev);
        if (out_valid) begin
          check("in_ready_in_drain", in_ready, 1'b0);
          if (exp_q.size() == 0) begin
            check("unexpected_out_valid", out_valid, 1'b0);
          end else if (out_ready) begin
            e = exp_q.pop_front();
            check("out_byte", {out_last, out_data}, e);
            n_acc++;
          end
        end
        stalled_prev = out_valid && !out_ready;
        prev = {out_valid, out_last, out_data};
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_block(input logic [7:0] b[8], input int len, input logic last);
    int w;
    for (int k = 0; k < len; k++) begin
      in_valid = 1'b1;
      in_data  = b[k];
      in_last  = (k == len - 1) && last;
      w = 0;
      while (!in_ready && w < 50) begin
        @(negedge clk);
        w++;
      end
      if (w >= 50) check("in_ready_wait", in_ready, 1'b1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Reference: block zero-padded to 8 bytes; core output is each byte inverted.
  task automatic model_block(input logic [7:0] b[8], input int len, input logic last,
                             output logic [7:0] p[8]);
    for (int k = 0; k < 8; k++) p[k] = (k < len) ? b[k] : 8'h00;
    for (int k = 0; k < 8; k++) exp_q.push_back({(k == 7) && last, ~p[k]});
  endtask

  task automatic run_block(input logic [7:0] b[8], input int len, input logic last,
                           input int lat, input int mode);
    logic [7:0] p[8];
    int cnt;
    stub_n = lat;
    ready_mode = mode;
    model_block(b, len, last, p);
    send_block(b, len, last);
    check("core_start_launch", core_start, 1'b1);
    check("core_v0", core_v0, {p[0], p[1], p[2], p[3]});
    check("core_v1", core_v1, {p[4], p[5], p[6], p[7]});
    @(negedge clk);
    check("core_start_pulse", core_start, 1'b0);
    cnt = 1;
    while (!out_valid && cnt < 400) begin
      @(negedge clk);
      cnt++;
    end
    check("first_out_latency", cnt, lat + 1);
    #2;
    cnt = 0;
    while (exp_q.size() > 0 && cnt < 200) begin
      @(negedge clk);
      #2;
      cnt++;
    end
    check("drain_complete", exp_q.size(), 0);
    if (mode == 0) check("drain_cycles", cnt, 7);
    exp_blocks++;
    @(negedge clk);
    check("block_count", block_count, exp_blocks);
    check("in_ready_after_drain", in_ready, 1'b1);
    check("out_valid_after_drain", out_valid, 1'b0);
    ready_mode = 0;
  endtask

  initial begin
    logic [7:0] blk1[8];
    logic [7:0] blk2[8];
    logic [7:0] rb[8];
    logic [7:0] p[8];
    int cnt;
    int base;
    int len;
    logic last;

    blk1 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    blk2 = '{8'hAA, 8'hBB, 8'hCC, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_core_start", core_start, 1'b0);
    check("rst_core_v", {core_v0, core_v1}, 64'h0);
    check("rst_timeout_err", timeout_err, 1'b0);
    check("rst_block_count", block_count, 16'd0);

    // Full block, full-rate output.
    run_block(blk1, 8, 1'b0, 98, 0);
    // Short block closed by in_last, zero padded.
    run_block(blk2, 3, 1'b1, 7, 0);
    // Full block with alternating downstream ready.
    run_block(blk1, 8, 1'b0, 98, 1);

    // Core never answers: block abandoned after the timeout window.
    stub_n = 0;
    send_block(blk1, 8, 1'b0);
    check("to_core_start", core_start, 1'b1);
    cnt = 0;
    while (!in_ready && cnt < 400) begin
      @(negedge clk);
      cnt++;
    end
    check("to_wait_cycles", cnt - 1, 255);
    check("to_timeout_err", timeout_err, 1'b1);
    check("to_block_count", block_count, exp_blocks);
    run_block(blk2, 3, 1'b1, 4, 0);
    check("to_err_sticky", timeout_err, 1'b1);

    // Reset in the middle of draining.
    stub_n = 5;
    ready_mode = 0;
    base = n_acc;
    model_block(blk1, 8, 1'b0, p);
    send_block(blk1, 8, 1'b0);
    cnt = 0;
    while (n_acc < base + 3 && cnt < 100) begin
      @(negedge clk);
      #2;
      cnt++;
    end
    check("mid_rst_reached", n_acc, base + 3);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    exp_blocks = 0;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_in_ready", in_ready, 1'b1);
    check("mid_rst_block_count", block_count, 16'd0);
    check("mid_rst_timeout_err", timeout_err, 1'b0);
    run_block(blk1, 8, 1'b0, 12, 0);

    // Done pulse on the final allowed WAIT cycle beats the timeout.
    run_block(blk2, 3, 1'b1, 255, 0);
    check("late_ready_no_err", timeout_err, 1'b0);

    // Randomised blocks.
    for (int r = 0; r < 8; r++) begin
      len = $urandom_range(1, 8);
      last = (len < 8) ? 1'b1 : 1'($urandom_range(0, 1));
      for (int k = 0; k < 8; k++) rb[k] = 8'($urandom_range(0, 255));
      run_block(rb, len, last, $urandom_range(1, 30), $urandom_range(0, 2));
    end
    check("final_timeout_err", timeout_err, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tea_stream_adapter.md
Name: tea_stream_adapter

Overview:
Byte-stream front/back end for the TEA `encrypt` core, sitting directly around it.
- Packs incoming bytes into the two DATA_WIDTH-bit words the core consumes.
- Launches the core with a one-cycle start pulse and waits for its ready pulse.
- Captures the result and serialises it back out as bytes under valid/ready flow control.
- Handles short final blocks and a core that never answers.

Parameters:
DATA_WIDTH, 32, width of each cipher half-word; must be a multiple of 8; block = 2*DATA_WIDTH/8 bytes (8 at default)
TIMEOUT_CYCLES, 255, max WAIT-state cycles before the block is abandoned
TIMEOUT_WIDTH, 8, timer width; must hold TIMEOUT_CYCLES-1
COUNT_WIDTH, 16, width of block_count

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  synchronous, active-high reset
in_data  in  8  input byte
in_valid  in  1  input byte valid
in_last  in  1  final byte of message; qualified by in_valid
in_ready  out  1  adapter accepts a byte this cycle
out_data  out  8  output byte
out_valid  out  1  output byte valid
out_last  out  1  last byte of a block that was closed by in_last
out_ready  in  1  downstream accepts out_data
core_start  out  1  start pulse to core
core_v0  out  DATA_WIDTH  first word to core (vi0)
core_v1  out  DATA_WIDTH  second word to core (vi1)
core_ready  in  1  core done pulse
core_o0  in  DATA_WIDTH  core result word 0 (vo0)
core_o1  in  DATA_WIDTH  core result word 1 (vo1)
timeout_err  out  1  sticky: a block was abandoned on timeout
block_count  out  COUNT_WIDTH  completed blocks, wraps to 0

Behaviour:
- Reset (clocked, rst=1) sets:
  - state=FILL; in_ready=1 from the next cycle.
  - out_valid=0, out_last=0, out_data=0, core_start=0.
  - core_v0=core_v1=0, input buffer=0, byte counters=0, timer=0.
  - timeout_err=0, block_count=0.
- Reset mid-operation discards any partial or in-flight block; no output is produced for it.
- Byte order is MSB-first:
  - byte 0 goes to core_v0[DATA_WIDTH-1:DATA_WIDTH-8]; core_v0 fills first, then core_v1.
  - Output uses the same order over {core_o0, core_o1}.
- FILL:
  - in_ready=1; a byte is accepted on in_valid&&in_ready and written at index byte_cnt.
  - Input buffer is zeroed at block start, so unfilled bytes are 0.
  - Go to LAUNCH when byte index 2*DATA_WIDTH/8-1 is accepted, or when any byte with in_last=1 is accepted (zero-padded block).
  - Record last_flag = in_last of the closing byte.
- LAUNCH (exactly 1 cycle):
  - core_start=1, in_ready=0, timer cleared; go to WAIT.
  - core_v0/core_v1 are driven from the buffer and held stable from LAUNCH until WAIT exits.
- WAIT:
  - core_start=0; timer increments each cycle; core_ready is ignored outside WAIT.
  - If core_ready=1: register core_o0/core_o1 into the output buffer and go to DRAIN.
  - Otherwise, if timer==TIMEOUT_CYCLES-1: set timeout_err=1, discard the block, go to FILL.
  - core_ready on the final WAIT cycle wins over timeout.
- DRAIN:
  - out_valid=1; out_data = byte out_cnt of the output buffer.
  - out_data, out_valid and out_last hold while out_ready=0.
  - out_last=1 only on the final byte and only if last_flag=1.
  - Advance on out_valid&&out_ready.
  - On acceptance of the final byte: block_count+1 (wrapping), go to FILL, clear counters and last_flag.
  - in_ready=0 throughout.
- Latency:
  - LAUNCH is the cycle after the closing byte is accepted.
  - First out_valid is the cycle after core_ready is sampled.
  - Output runs at 1 byte/cycle with out_ready held high.
- No overlap: a new block is not accepted until the previous block is fully drained or abandoned.
- timeout_err is cleared only by rst.

Test Plan:
(The bench uses a stub core: core_ready pulses N cycles after core_start, with core_o0=~core_v0 and core_o1=~core_v1.)
1. Bytes 01..08 on consecutive cycles, N=98, out_ready=1 -> core_v0=0x01020304, core_v1=0x05060708, single-cycle core_start the cycle after byte 08; out bytes FE FD FC FB FA F9 F8 F7 on 8 consecutive cycles; out_last=0; block_count=1.
2. AA, BB, CC with in_last on CC -> core_v0=0xAABBCC00, core_v1=0; out 55 44 33 FF FF FF FF FF; out_last=1 only with the 8th byte.
3. Test 1 with out_ready alternating 1/0 -> each byte held stable while stalled; in_ready=0 during DRAIN; all 8 bytes delivered in order; block_count=1.
4. Stub never asserts core_ready -> WAIT lasts exactly 255 cycles; timeout_err=1; in_ready=1 the next cycle; no out_valid; block_count=0; a following good block completes normally and timeout_err stays 1.
5. Stub core_ready on the 255th WAIT cycle -> result accepted; timeout_err=0; block drains normally.
6. rst asserted after 3 output bytes accepted -> next cycle out_valid=0, in_ready=1, block_count=0, timeout_err=0; the next block of 8 bytes processes correctly.
